// File: rtl/clock_phase_controller.sv
`default_nettype none
// ============================================================================
// Module      : clock_phase_controller
// Description : Two-phase non-overlapping clk1/clk2 generator for the CPU
//               timing generator. Tracks the 8-period instruction cycle
//               (A1..X3) and offers run / halt / single-step control that
//               only ever stops the clocks on an instruction-cycle boundary.
//               Optional macro CLOCK_PHASE_CONTROLLER_CYCCOUNT_EN adds a
//               16-bit wrapping count of completed instruction cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_phase_controller #(
  parameter int P1W = 2,  // sysclk cycles clk1 is high
  parameter int G12 = 1,  // gap after clk1 falls
  parameter int P2W = 2,  // sysclk cycles clk2 is high
  parameter int G21 = 1,  // gap after clk2 falls
  parameter int CW  = 4   // sub-period counter width
) (
  input  logic       sysclk,
  input  logic       resetn,
  input  logic       run,
  input  logic       step,
  output logic       clk1,
  output logic       clk2,
  output logic [2:0] phase,
  output logic       cyc_end,
  output logic       halted
`ifdef CLOCK_PHASE_CONTROLLER_CYCCOUNT_EN
  ,
  output logic [15:0] cyc_count
`endif
);

  localparam int            c_PER      = P1W + G12 + P2W + G21;
  localparam logic [CW-1:0] c_SUB_LAST = CW'(c_PER - 1);
  localparam logic [CW-1:0] c_P1_END   = CW'(P1W);
  localparam logic [CW-1:0] c_P2_BEG   = CW'(P1W + G12);
  localparam logic [CW-1:0] c_P2_END   = CW'(P1W + G12 + P2W);

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] sub_q, sub_d;
  logic [2:0]    phase_q, phase_d;
  logic          clk1_q, clk1_d;
  logic          clk2_q, clk2_d;
  logic          cyc_end_q, cyc_end_d;
  logic          halted_q, halted_d;
  logic          w_sub_wrap;
  logic          w_cyc_last;

  assign w_sub_wrap = (sub_q == c_SUB_LAST);
  assign w_cyc_last = w_sub_wrap && (phase_q == 3'd7);

  // Next-state logic; the strobes are decoded from the *next* sub value so
  // they are registered and move on the same edge as the counter.
  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    phase_d = phase_q;
    unique case (state_q)
      S_HALT: begin
        sub_d   = '0;
        phase_d = 3'd0;
        // run wins over a simultaneous step; the step is simply dropped
        if (run)       state_d = S_RUN;
        else if (step) state_d = S_STEP;
      end
      S_RUN, S_STEP: begin
        if (w_cyc_last) begin
          // Boundary decision for both modes: keep going only while run is high
          sub_d   = '0;
          phase_d = 3'd0;
          state_d = run ? S_RUN : S_HALT;
        end else if (w_sub_wrap) begin
          sub_d   = '0;
          phase_d = phase_q + 3'd1;
        end else begin
          sub_d   = sub_q + CW'(1);
        end
      end
      default: begin
        state_d = S_HALT;
        sub_d   = '0;
        phase_d = 3'd0;
      end
    endcase
    clk1_d    = (state_d != S_HALT) && (sub_d < c_P1_END);
    clk2_d    = (state_d != S_HALT) && (sub_d >= c_P2_BEG) && (sub_d < c_P2_END);
    cyc_end_d = (state_d != S_HALT) && (sub_d == c_SUB_LAST) && (phase_d == 3'd7);
    halted_d  = (state_d == S_HALT);
  end

  // State and output registers; reset parks the clocks immediately
  always_ff @(posedge sysclk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_HALT;
      sub_q     <= '0;
      phase_q   <= 3'd0;
      clk1_q    <= 1'b0;
      clk2_q    <= 1'b0;
      cyc_end_q <= 1'b0;
      halted_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      sub_q     <= sub_d;
      phase_q   <= phase_d;
      clk1_q    <= clk1_d;
      clk2_q    <= clk2_d;
      cyc_end_q <= cyc_end_d;
      halted_q  <= halted_d;
    end
  end

  assign clk1    = clk1_q;
  assign clk2    = clk2_q;
  assign phase   = phase_q;
  assign cyc_end = cyc_end_q;
  assign halted  = halted_q;

`ifdef CLOCK_PHASE_CONTROLLER_CYCCOUNT_EN
  logic [15:0] cyc_count_q;

  // Count completed instruction cycles; wraps naturally at 16 bits
  always_ff @(posedge sysclk or negedge resetn) begin
    if (!resetn) begin
      cyc_count_q <= 16'd0;
    end else if (cyc_end_q) begin
      cyc_count_q <= cyc_count_q + 16'd1;
    end
  end

  assign cyc_count = cyc_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clock_phase_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_phase_controller
// Description : Self-checking bench for clock_phase_controller. A reference
//               model tracks one linear sysclk index through the instruction
//               cycle and derives every expected output arithmetically.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_phase_controller;

  localparam int P1W = 2;
  localparam int G12 = 1;
  localparam int P2W = 2;
  localparam int G21 = 1;
  localparam int CW  = 4;
  localparam int PER = P1W + G12 + P2W + G21;
  localparam int CYC = 8 * PER;

  logic       sysclk;
  logic       resetn;
  logic       run;
  logic       step;
  logic       clk1;
  logic       clk2;
  logic [2:0] phase;
  logic       cyc_end;
  logic       halted;
`ifdef CLOCK_PHASE_CONTROLLER_CYCCOUNT_EN
  logic [15:0] cyc_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  clock_phase_controller #(
    .P1W(P1W), .G12(G12), .P2W(P2W), .G21(G21), .CW(CW)
  ) dut (
    .sysclk (sysclk),
    .resetn (resetn),
    .run    (run),
    .step   (step),
    .clk1   (clk1),
    .clk2   (clk2),
    .phase  (phase),
    .cyc_end(cyc_end),
    .halted (halted)
`ifdef CLOCK_PHASE_CONTROLLER_CYCCOUNT_EN
    ,
    .cyc_count(cyc_count)
`endif
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Reference model: active flag plus sysclk index t within the instruction cycle
  bit m_act;
  int m_t;

  always @(posedge sysclk or negedge resetn) begin
    if (!resetn) begin
      m_act <= 1'b0;
      m_t   <= 0;
    end else if (!m_act) begin
      if (run || step) begin
        m_act <= 1'b1;
        m_t   <= 0;
      end
    end else if (m_t == CYC - 1) begin
      m_act <= run;
      m_t   <= 0;
    end else begin
      m_t   <= m_t + 1;
    end
  end

  // Expected {clk1, clk2, phase, cyc_end, halted}
  function automatic logic [6:0] exp_vec();
    int s;
    if (!m_act) return 7'b0000001;
    s = m_t % PER;
    return {s < P1W, (s >= P1W + G12) && (s < P1W + G12 + P2W),
            3'(m_t / PER), m_t == CYC - 1, 1'b0};
  endfunction

  logic [6:0] dut_vec;
  assign dut_vec = {clk1, clk2, phase, cyc_end, halted};

  task automatic test_reset();
    resetn = 1'b0; run = 1'b0; step = 1'b0;
    repeat (3) @(negedge sysclk);
    n_checks++;
    if (dut_vec !== 7'b0000001) begin
      n_fail++;
      $display("FAIL reset_state: got %b want %b", dut_vec, 7'b0000001);
    end
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge sysclk);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_parked: got %b want %b", dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_free_run();
    int ends = 0;
    run = 1'b1;
    for (int i = 0; i < 3 * CYC; i++) begin
      @(negedge sysclk);
      n_checks++;
      if (dut_vec !== exp_vec() || (clk1 && clk2)) begin
        n_fail++;
        $display("FAIL free_run cyc %0d: got %b want %b", i, dut_vec, exp_vec());
      end
      if (cyc_end) ends++;
    end
    n_checks++;
    if (ends !== 3) begin
      n_fail++;
      $display("FAIL free_run_cyc_end_count: got %0d want 3", ends);
    end
    run = 1'b0;
    for (int i = 0; i < CYC + 2; i++) begin
      @(negedge sysclk);
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL free_run_stop: got %b want %b", dut_vec, exp_vec());
      end
    end
    n_checks++;
    if (halted !== 1'b1) begin
      n_fail++;
      $display("FAIL free_run_halt: halted got %b want 1", halted);
    end
  endtask

  task automatic test_step();
    int r1 = 0, r2 = 0, ends = 0;
    logic p1 = 1'b0, p2 = 1'b0;
    step = 1'b1;
    for (int i = 0; i < CYC + 4; i++) begin
      @(negedge sysclk);
      step = 1'b0;
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL step cyc %0d: got %b want %b", i, dut_vec, exp_vec());
      end
      if (clk1 && !p1) r1++;
      if (clk2 && !p2) r2++;
      if (cyc_end) ends++;
      p1 = clk1; p2 = clk2;
    end
    n_checks++;
    if (r1 !== 8 || r2 !== 8 || ends !== 1 || halted !== 1'b1 || phase !== 3'd0) begin
      n_fail++;
      $display("FAIL step_totals: clk1=%0d clk2=%0d cyc_end=%0d halted=%b phase=%0d want 8 8 1 1 0",
               r1, r2, ends, halted, phase);
    end
  endtask

  task automatic test_run_drop();
    bit dropped = 0;
    bit done = 0;
    int seen_halt = 0;
    run = 1'b1;
    for (int i = 0; i < 3 * CYC && !done; i++) begin
      @(negedge sysclk);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL run_drop: got %b want %b", dut_vec, exp_vec());
      end
      if (dropped && halted) done = 1;
      if (!dropped && m_act && (m_t / PER) == 3) begin
        run = 1'b0;
        dropped = 1;
      end
    end
    n_checks++;
    if (!done || clk1 !== 1'b0 || clk2 !== 1'b0) begin
      n_fail++;
      $display("FAIL run_drop_halt: halted=%b clk1=%b clk2=%b want 1 0 0", halted, clk1, clk2);
    end
    // Drop during phase 3, re-assert during phase 5: must never halt
    run = 1'b1;
    @(negedge sysclk);
    for (int i = 0; i < 2 * CYC; i++) begin
      @(negedge sysclk);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL run_reassert: got %b want %b", dut_vec, exp_vec());
      end
      if (halted) seen_halt++;
      run = !(m_act && (m_t / PER) >= 3 && (m_t / PER) < 5);
    end
    n_checks++;
    if (seen_halt !== 0) begin
      n_fail++;
      $display("FAIL run_reassert_nohalt: halted cycles got %0d want 0", seen_halt);
    end
    run = 1'b0;
    for (int i = 0; i < CYC + 2; i++) @(negedge sysclk);
  endtask

  task automatic test_run_and_step();
    int ends = 0;
    run = 1'b1; step = 1'b1;
    for (int i = 0; i < CYC + 10; i++) begin
      @(negedge sysclk);
      step = 1'b0;
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL run_step_both: got %b want %b", dut_vec, exp_vec());
      end
    end
    run = 1'b0;
    for (int i = 0; i < 2 * CYC && !halted; i++) begin
      @(negedge sysclk);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL run_step_stop: got %b want %b", dut_vec, exp_vec());
      end
      if (cyc_end) ends++;
    end
    n_checks++;
    if (ends !== 1 || halted !== 1'b1) begin
      n_fail++;
      $display("FAIL run_step_single_boundary: cyc_end=%0d halted=%b want 1 1", ends, halted);
    end
  endtask

  task automatic test_async_reset();
    bit hit = 0;
    run = 1'b1;
    for (int i = 0; i < 2 * CYC && !hit; i++) begin
      @(negedge sysclk);
      if (m_act && (m_t / PER) == 4 && (m_t % PER) >= P1W + G12 &&
          (m_t % PER) < P1W + G12 + P2W) hit = 1;
    end
    n_checks++;
    if (!hit || clk2 !== 1'b1 || phase !== 3'd4) begin
      n_fail++;
      $display("FAIL async_setup: clk2=%b phase=%0d want 1 4", clk2, phase);
    end
    #2 resetn = 1'b0;
    run = 1'b0;
    #1;
    n_checks++;
    if (dut_vec !== 7'b0000001) begin
      n_fail++;
      $display("FAIL async_reset_immediate: got %b want %b", dut_vec, 7'b0000001);
    end
    @(negedge sysclk);
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge sysclk);
      n_checks++;
      if (dut_vec !== 7'b0000001) begin
        n_fail++;
        $display("FAIL async_parked: got %b want %b", dut_vec, 7'b0000001);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1200; i++) begin
      @(negedge sysclk);
      n_checks++;
      if (dut_vec !== exp_vec() || (clk1 && clk2)) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %b want %b", i, dut_vec, exp_vec());
      end
      if ($urandom_range(0, 39) == 0) run = ~run;
      step = ($urandom_range(0, 24) == 0);
    end
    run = 1'b0; step = 1'b0;
    for (int i = 0; i < CYC + 2; i++) @(negedge sysclk);
  endtask

`ifdef CLOCK_PHASE_CONTROLLER_CYCCOUNT_EN
  task automatic test_cyccount();
    logic [15:0] c0;
    c0 = cyc_count;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        n_checks++;
        if (cyc_count !== c0 + 16'd3) begin
          n_fail++;
          $display("FAIL cyccount_three: got %h want %h", cyc_count, c0 + 16'd3);
        end
        force dut.cyc_count_q = 16'hFFFF;
        @(negedge sysclk);
        release dut.cyc_count_q;
      end
      step = 1'b1;
      @(negedge sysclk);
      step = 1'b0;
      for (int i = 0; i < CYC + 2; i++) @(negedge sysclk);
    end
    n_checks++;
    if (cyc_count !== 16'h0000) begin
      n_fail++;
      $display("FAIL cyccount_wrap: got %h want 0000", cyc_count);
    end
  endtask
`endif

  initial begin
    resetn = 1'b0; run = 1'b0; step = 1'b0;
    test_reset();
    test_free_run();
    test_step();
    test_run_drop();
    test_run_and_step();
    test_async_reset();
    test_random();
`ifdef CLOCK_PHASE_CONTROLLER_CYCCOUNT_EN
    test_cyccount();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
